chip8_draw_seq: RTL and testbench
=================================

Name: chip8_draw_seq

Overview:
Multi-cycle sequencer for the DXYN draw instruction. It is started by the instruction core and fetches N sprite bytes from RAM through a req/ack port. Each byte is XOR-composited into one 64-bit row of the row-addressed framebuffer by read-modify-write, and the sequencer reports the VF collision flag. It owns the framebuffer write port and the sprite-read RAM port while busy; the core stalls PC until done.

Parameters:
DISP_W, 64, framebuffer width in pixels (row width in bits)
DISP_H, 32, framebuffer height in rows
ADDR_W, 12, RAM address width

Ports:
instruction_clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
x_in  in  8  VX value
y_in  in  8  VY value
n_in  in  4  sprite height N
i_addr  in  ADDR_W  register I
busy  out  1  high from cycle after accepted start until DONE exits
done  out  1  one-cycle pulse at completion
collision  out  1  VF result; valid with done, held until next accepted start
mem_req  out  1  sprite byte read request
mem_addr  out  ADDR_W  read address, stable while mem_req high
mem_ack  in  1  read complete; mem_rdata valid this cycle
mem_rdata  in  8  sprite byte
fb_row  out  $clog2(DISP_H)  framebuffer row index
fb_rdata  in  DISP_W  current row contents, combinational from fb_row
fb_we  out  1  row write strobe
fb_wdata  out  DISP_W  new row contents

Behaviour:
- Interface: one clock (instruction_clk); reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, collision=0, mem_req=0, mem_addr=0, fb_we=0, fb_row=0, fb_wdata=0. State=IDLE, row counter r=0.
- Pixel mapping: row bit c = column c (bit 0 leftmost). Sprite bit 7 maps to column x0.
- On accepted start, latch:
  - x0 = x_in mod DISP_W and y0 = y_in mod DISP_H (start position wraps).
  - n = n_in and base = i_addr.
  - collision cleared.
- Clipping, no wrap past the edge: columns x0+k >= DISP_W are dropped. Rows y0+r >= DISP_H end the draw.
- States:
  - IDLE: on start with n_in != 0, go to FETCH. On start with n_in == 0, go to DONE with no RAM access. start while not IDLE is ignored.
  - FETCH: mem_req=1, mem_addr = (base + r) mod 2^ADDR_W, so the address wraps 0xFFF to 0x000. Hold until mem_ack; ack may arrive in the same cycle as req. Latch mem_rdata on ack, drop mem_req next cycle, go to WRITE.
  - WRITE (1 cycle):
    - fb_row = y0 + r; mask = sprite byte shifted to x0 and clipped.
    - fb_we=1, fb_wdata = fb_rdata ^ mask.
    - collision |= |(fb_rdata & mask).
    - Then r++. If r == n or y0 + r >= DISP_H, go to DONE; else go to FETCH.
  - DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Latency: with zero-wait ack and all rows visible, done is asserted 2N+1 cycles after the start edge. N=0 gives done 1 cycle after start. Each ack wait cycle adds 1.
- fb_we is only ever high in WRITE; exactly one write per visible row.
- Reset mid-operation: next edge forces IDLE. mem_req drops, no further fb_we, no done pulse, collision=0. Rows already written stay written.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package chip8_pkg holds:
  - DISP_W/DISP_H defaults and FONT_BASE (80).
  - the draw_state enum {IDLE, FETCH, WRITE, DONE}.
  - a row-index width constant.
- One natural sub-module: chip8_sprite_mask. It is combinational: (byte, x0) -> DISP_W-bit clipped mask, and is reused by any future SCHIP 16-bit-wide draw.

Test Plan:
- Font "0" draw: blank fb, x=0, y=0, n=5, I=0x050 (F0 90 90 90 F0), zero-wait ack.
  - Required: rows 0..4 written; row0 bits 0-3 = 1; row1 bits 0 and 3 = 1; collision=0; done at start+11.
- Redraw the same sprite:
  - Required: rows 0..4 become all zero; collision=1.
- x clipping: x=62, y=0, n=1, byte 0xFF.
  - Required: only columns 62 and 63 set.
- x wrap: x=70, y=0, n=1, byte 0xFF.
  - Required: columns 6..13 set.
- y clipping with address wrap: y=30, n=5, I=0xFFF, ack delayed 3 cycles.
  - Required: mem_addr 0xFFF then 0x000, each stable while req is high.
  - Required: only rows 30 and 31 written; exactly 2 reads; done after clip.
- Control corners:
  - Assert rst during the row-2 WRITE. Required: busy=0 next cycle; no further fb_we or done.
  - Pulse start while busy. Required: it is ignored.
  - Start with n=0. Required: done at start+1, mem_req never high.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants: display geometry, font location and draw sequencer states.
package chip8_pkg;

  localparam int unsigned DEF_DISP_W = 64;
  localparam int unsigned DEF_DISP_H = 32;
  localparam int unsigned FONT_BASE  = 80;
  localparam int unsigned ROW_W      = $clog2(DEF_DISP_H);

  typedef logic [1:0] draw_state_t;

  localparam draw_state_t IDLE  = 2'd0;
  localparam draw_state_t FETCH = 2'd1;
  localparam draw_state_t WRITE = 2'd2;
  localparam draw_state_t DONE  = 2'd3;

endpackage

// File: rtl/chip8_sprite_mask.sv
// Places an 8-pixel sprite byte at column x0 of a row; columns past the right edge are dropped.
module chip8_sprite_mask
  import chip8_pkg::*;
#(
  parameter int unsigned DISP_W = DEF_DISP_W
) (
  input  logic [7:0]                sprite,
  input  logic [$clog2(DISP_W)-1:0] x0,
  output logic [DISP_W-1:0]         mask
);

  localparam int unsigned XW = $clog2(DISP_W);

  logic [XW:0] col;

  // Sprite bit 7 is the leftmost pixel and lands on column x0 (row bit x0).
  always_comb begin
    mask = '0;
    col  = '0;
    for (int k = 0; k < 8; k++) begin
      col = {1'b0, x0} + (XW + 1)'(k);
      if (col < (XW + 1)'(DISP_W)) begin
        mask[col[XW-1:0]] = sprite[3'(7 - k)];
      end
    end
  end

endmodule

// File: rtl/chip8_draw_seq.sv
// DXYN draw sequencer: fetches N sprite bytes and XOR-composites each into a framebuffer row.
module chip8_draw_seq
  import chip8_pkg::*;
#(
  parameter int unsigned DISP_W = DEF_DISP_W,
  parameter int unsigned DISP_H = DEF_DISP_H,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                      instruction_clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                x_in,
  input  logic [7:0]                y_in,
  input  logic [3:0]                n_in,
  input  logic [ADDR_W-1:0]         i_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      collision,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [7:0]                mem_rdata,
  output logic [$clog2(DISP_H)-1:0] fb_row,
  input  logic [DISP_W-1:0]         fb_rdata,
  output logic                      fb_we,
  output logic [DISP_W-1:0]         fb_wdata
);

  localparam int unsigned XW = $clog2(DISP_W);
  localparam int unsigned RW = $clog2(DISP_H);

  draw_state_t       state_q, state_d;
  logic [XW-1:0]     x0_q;
  logic [RW-1:0]     y0_q;
  logic [3:0]        n_q;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        r_q;
  logic [7:0]        sprite_q;
  logic              collision_q;

  logic [4:0]        r_next;
  logic [8:0]        row_next;
  logic              last_row;
  logic [DISP_W-1:0] mask;

  chip8_sprite_mask #(
    .DISP_W (DISP_W)
  ) u_mask (
    .sprite (sprite_q),
    .x0     (x0_q),
    .mask   (mask)
  );

  assign r_next   = r_q + 5'd1;
  assign row_next = 9'(y0_q) + 9'(r_next);
  // The draw stops at N rows or at the bottom edge, whichever comes first.
  assign last_row = (r_next == {1'b0, n_q}) || (row_next >= 9'(DISP_H));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_in != 4'd0) ? FETCH : DONE;
      FETCH:   if (mem_ack) state_d = WRITE;
      WRITE:   state_d = last_row ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge instruction_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      base_q      <= '0;
      r_q         <= '0;
      sprite_q    <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        x0_q        <= XW'(x_in % 8'(DISP_W));
        y0_q        <= RW'(y_in % 8'(DISP_H));
        n_q         <= n_in;
        base_q      <= i_addr;
        r_q         <= '0;
        collision_q <= 1'b0;
      end
      if (state_q == FETCH && mem_ack) begin
        sprite_q <= mem_rdata;
      end
      if (state_q == WRITE) begin
        collision_q <= collision_q | (|(fb_rdata & mask));
        r_q         <= r_next;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_req   = (state_q == FETCH);
  assign fb_we     = (state_q == WRITE);
  assign collision = collision_q;
  assign mem_addr  = base_q + ADDR_W'(r_q);
  assign fb_row    = y0_q + RW'(r_q);
  assign fb_wdata  = fb_we ? (fb_rdata ^ mask) : '0;

endmodule

// File: tb/tb_chip8_draw_seq.sv
// Bench for chip8_draw_seq: RAM and framebuffer models around the DUT, checked against a sprite-draw model.
module tb_chip8_draw_seq;

  logic        instruction_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x_in = '0, y_in = '0;
  logic [3:0]  n_in = '0;
  logic [11:0] i_addr = '0;
  logic        busy, done, collision, mem_req, mem_ack, fb_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [4:0]  fb_row;
  logic [63:0] fb_rdata, fb_wdata;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram    [4096];
  logic [63:0] fb     [32];
  logic [63:0] exp_fb [32];

  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          fb_clear = 0;
  int          reads = 0, writes = 0, dones = 0;
  bit          req_seen = 0, addr_unstable = 0, pend = 0;
  logic [11:0] prev_addr = '0;
  logic [11:0] addr_log[$];
  int          row_log[$];

  chip8_draw_seq dut (
    .instruction_clk (instruction_clk),
    .rst             (rst),
    .start           (start),
    .x_in            (x_in),
    .y_in            (y_in),
    .n_in            (n_in),
    .i_addr          (i_addr),
    .busy            (busy),
    .done            (done),
    .collision       (collision),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .fb_row          (fb_row),
    .fb_rdata        (fb_rdata),
    .fb_we           (fb_we),
    .fb_wdata        (fb_wdata)
  );

  always #5 instruction_clk = ~instruction_clk;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = ram[mem_addr];
  assign fb_rdata  = fb[fb_row];

  // RAM responder, framebuffer storage and bus monitors.
  always @(posedge instruction_clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (fb_clear) begin
      for (int j = 0; j < 32; j++) fb[j] <= '0;
    end else if (fb_we) begin
      fb[fb_row] <= fb_wdata;
    end
    if (mem_req && mem_ack) begin
      reads++;
      addr_log.push_back(mem_addr);
    end
    if (mem_req && pend && mem_addr != prev_addr) addr_unstable = 1;
    pend      = mem_req && !mem_ack;
    prev_addr = mem_addr;
    if (fb_we) begin
      writes++;
      row_log.push_back(int'(fb_row));
    end
    if (done) dones++;
    if (mem_req) req_seen = 1;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // Reference: sprite drawing from the DXYN rules on plain integers.
  task automatic model_draw(input int x, input int y, input int n, input int i,
                            output bit coll, output int vis);
    int          x0, y0;
    logic [7:0]  b, t;
    logic [4:0]  row;
    logic [63:0] bm;
    x0 = x % 64;
    y0 = y % 32;
    coll = 0;
    vis = 0;
    for (int r = 0; r < n; r++) begin
      if (y0 + r >= 32) break;
      b   = ram[12'(i + r)];
      row = 5'(y0 + r);
      vis++;
      for (int k = 0; k < 8; k++) begin
        t = b >> (7 - k);
        if (t[0] && (x0 + k < 64)) begin
          bm = 64'd1 << (x0 + k);
          if ((exp_fb[row] & bm) != 0) coll = 1;
          exp_fb[row] = exp_fb[row] ^ bm;
        end
      end
    end
  endtask

  function automatic int fb_diff();
    for (int j = 0; j < 32; j++) if (fb[j] !== exp_fb[j]) return j;
    return -1;
  endfunction

  task automatic clear_all();
    @(negedge instruction_clk);
    fb_clear = 1;
    @(posedge instruction_clk);
    #1 fb_clear = 0;
    for (int j = 0; j < 32; j++) exp_fb[j] = '0;
  endtask

  // Issues one draw and returns cycles from the start edge to the edge that samples done.
  task automatic run_draw(input int x, input int y, input int n, input int i, input int d,
                          input bit poke, output int lat);
    @(negedge instruction_clk);
    ack_delay = d;
    reads = 0; writes = 0; dones = 0;
    req_seen = 0; addr_unstable = 0;
    addr_log.delete();
    row_log.delete();
    x_in = 8'(x); y_in = 8'(y); n_in = 4'(n); i_addr = 12'(i);
    start = 1;
    @(posedge instruction_clk);
    #1 start = 0;
    lat = 1;
    while (!done && lat < 300) begin
      if (poke && lat == 3) begin
        n_in = 4'd0;
        x_in = 8'($urandom);
        start = 1;
      end else begin
        start = 0;
      end
      @(posedge instruction_clk);
      #1 lat++;
    end
    start = 0;
    if (!done) lat = -1;
    @(posedge instruction_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge instruction_clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++;
    if (collision !== 1'b0) begin fails++; $display("FAIL reset_coll: got %b want 0", collision); end
    tests++;
    if (mem_req !== 1'b0 || mem_addr !== 12'h000) begin
      fails++; $display("FAIL reset_mem: req %b addr %h want 0 000", mem_req, mem_addr);
    end
    tests++;
    if (fb_we !== 1'b0 || fb_row !== 5'd0 || fb_wdata !== 64'd0) begin
      fails++; $display("FAIL reset_fb: we %b row %0d wdata %h want all zero", fb_we, fb_row, fb_wdata);
    end
    // Reset wins over a coincident start.
    n_in = 4'd3;
    start = 1;
    @(posedge instruction_clk);
    #1 start = 0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_vs_start: busy %b want 0", busy); end
    rst = 0;
    @(posedge instruction_clk);
    #1;
  endtask

  task automatic test_font0();
    bit c; int v, lat, df;
    clear_all();
    ram[12'h050] = 8'hF0; ram[12'h051] = 8'h90; ram[12'h052] = 8'h90;
    ram[12'h053] = 8'h90; ram[12'h054] = 8'hF0;
    model_draw(0, 0, 5, 12'h050, c, v);
    run_draw(0, 0, 5, 12'h050, 0, 0, lat);
    tests++; if (lat !== 11) begin fails++; $display("FAIL font0_latency: got %0d want 11", lat); end
    tests++;
    if (fb[0] !== 64'hF) begin fails++; $display("FAIL font0_row0: got %h want %h", fb[0], 64'hF); end
    tests++;
    if (fb[1] !== 64'h9) begin fails++; $display("FAIL font0_row1: got %h want %h", fb[1], 64'h9); end
    tests++;
    if (collision !== 1'b0) begin fails++; $display("FAIL font0_coll: got %b want 0", collision); end
    tests++;
    if (writes !== 5 || reads !== 5) begin
      fails++; $display("FAIL font0_counts: writes %0d reads %0d want 5 5", writes, reads);
    end
    df = fb_diff();
    tests++; if (df != -1) begin fails++; $display("FAIL font0_fb: row %0d got %h want %h", df, fb[df], exp_fb[df]); end
  endtask

  task automatic test_redraw();
    bit c; int v, lat, df;
    model_draw(0, 0, 5, 12'h050, c, v);
    run_draw(0, 0, 5, 12'h050, 0, 0, lat);
    tests++;
    if (collision !== 1'b1) begin fails++; $display("FAIL redraw_coll: got %b want 1", collision); end
    df = fb_diff();
    tests++;
    if (df != -1 || fb[0] !== 64'd0 || fb[4] !== 64'd0) begin
      fails++; $display("FAIL redraw_clear: row0 %h row4 %h want 0", fb[0], fb[4]);
    end
  endtask

  task automatic test_x_edges();
    int lat;
    clear_all();
    ram[12'h200] = 8'hFF;
    run_draw(62, 0, 1, 12'h200, 0, 0, lat);
    tests++;
    if (fb[0] !== 64'hC000_0000_0000_0000 || lat !== 3) begin
      fails++; $display("FAIL x_clip: row0 %h lat %0d want c000000000000000 3", fb[0], lat);
    end
    clear_all();
    run_draw(70, 0, 1, 12'h200, 0, 0, lat);
    tests++;
    if (fb[0] !== 64'h3FC0) begin fails++; $display("FAIL x_wrap: row0 %h want %h", fb[0], 64'h3FC0); end
  endtask

  task automatic test_y_clip_wrap();
    bit c; int v, lat, df, x;
    clear_all();
    x = $urandom_range(0, 56);
    model_draw(x, 30, 5, 12'hFFF, c, v);
    run_draw(x, 30, 5, 12'hFFF, 3, 0, lat);
    tests++; if (lat !== 11) begin fails++; $display("FAIL yclip_latency: got %0d want 11", lat); end
    tests++;
    if (reads !== 2 || addr_log.size() != 2) begin
      fails++; $display("FAIL yclip_reads: got %0d want 2", reads);
    end else if (addr_log[0] !== 12'hFFF || addr_log[1] !== 12'h000) begin
      fails++; $display("FAIL yclip_addr: got %h %h want fff 000", addr_log[0], addr_log[1]);
    end
    tests++;
    if (addr_unstable) begin fails++; $display("FAIL yclip_addr_stable: address moved while req high, want stable"); end
    tests++;
    if (row_log.size() != 2) begin
      fails++; $display("FAIL yclip_rows: %0d writes want 2", row_log.size());
    end else if (row_log[0] != 30 || row_log[1] != 31) begin
      fails++; $display("FAIL yclip_rows: rows %0d %0d want 30 31", row_log[0], row_log[1]);
    end
    df = fb_diff();
    tests++; if (df != -1) begin fails++; $display("FAIL yclip_fb: row %0d got %h want %h", df, fb[df], exp_fb[df]); end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_all();
    @(negedge instruction_clk);
    ack_delay = 0;
    x_in = 8'd5; y_in = 8'd0; n_in = 4'd5; i_addr = 12'h300;
    start = 1;
    @(posedge instruction_clk);
    #1 start = 0;
    k = 0;
    while (!(fb_we && fb_row == 5'd2) && k < 50) begin
      @(posedge instruction_clk);
      #1 k++;
    end
    tests++;
    if (k >= 50) begin fails++; $display("FAIL rstmid_reach: row-2 write not seen, want seen"); end
    rst = 1;
    @(posedge instruction_clk);
    #1 rst = 0;
    tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || collision !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state: busy %b req %b done %b coll %b want 0000", busy, mem_req, done, collision);
    end
    writes = 0; dones = 0;
    repeat (20) @(posedge instruction_clk);
    #1;
    tests++;
    if (writes != 0 || dones != 0) begin
      fails++; $display("FAIL rstmid_quiet: writes %0d dones %0d want 0 0", writes, dones);
    end
  endtask

  task automatic test_start_busy();
    bit c; int v, lat, df;
    clear_all();
    model_draw(9, 4, 3, 12'h400, c, v);
    run_draw(9, 4, 3, 12'h400, 2, 1, lat);
    tests++;
    if (lat !== 13 || dones != 1) begin
      fails++; $display("FAIL busy_start: lat %0d dones %0d want 13 1", lat, dones);
    end
    df = fb_diff();
    tests++; if (df != -1) begin fails++; $display("FAIL busy_start_fb: row %0d got %h want %h", df, fb[df], exp_fb[df]); end
  endtask

  task automatic test_n_zero();
    int lat;
    run_draw(3, 3, 0, 12'h123, 0, 0, lat);
    tests++;
    if (lat !== 1 || req_seen || writes != 0) begin
      fails++; $display("FAIL n_zero: lat %0d req %b writes %0d want 1 0 0", lat, req_seen, writes);
    end
    tests++;
    if (collision !== 1'b0) begin fails++; $display("FAIL n_zero_coll: got %b want 0", collision); end
  endtask

  task automatic test_random();
    bit c; int v, lat, df, x, y, n, i, d, exp_lat;
    clear_all();
    for (int it = 0; it < 30; it++) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      n = $urandom_range(0, 15);
      i = $urandom_range(0, 4095);
      d = $urandom_range(0, 2);
      model_draw(x, y, n, i, c, v);
      exp_lat = (v == 0) ? 1 : v * (2 + d) + 1;
      run_draw(x, y, n, i, d, 0, lat);
      tests++;
      if (lat !== exp_lat || reads != v || writes != v) begin
        fails++;
        $display("FAIL rand_timing[%0d]: lat %0d reads %0d writes %0d want %0d %0d %0d",
                 it, lat, reads, writes, exp_lat, v, v);
      end
      tests++;
      if (collision !== c) begin fails++; $display("FAIL rand_coll[%0d]: got %b want %b", it, collision, c); end
      df = fb_diff();
      tests++;
      if (df != -1) begin
        fails++; $display("FAIL rand_fb[%0d]: row %0d got %h want %h", it, df, fb[df], exp_fb[df]);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 4096; j++) ram[j] = 8'($urandom);
    for (int j = 0; j < 32; j++) begin
      fb[j] = '0;
      exp_fb[j] = '0;
    end
    test_reset();
    test_font0();
    test_redraw();
    test_x_edges();
    test_y_clip_wrap();
    test_reset_mid();
    test_start_busy();
    test_n_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
